sdp_ram_fifo_ctrl: RTL and testbench
====================================

Name: sdp_ram_fifo_ctrl

Overview:
Single-clock FIFO controller that owns the write and read ports of an external simple_dual_port_ram instance. Both RAM clocks tie to clk. It accepts a valid/ready input stream and writes it into the RAM. It prefetches RAM reads into a small skid buffer so the output stream runs at full throughput, even with the RAM output register enabled. It sits directly upstream of the RAM, driving its write/read address and enable pins, and consumes rdata.

Parameters:
DATA_WIDTH, 8, stream and RAM data width
ADDR_WIDTH, 9, RAM address width; FIFO depth DEPTH = 2**ADDR_WIDTH
OUTPUT_REG, "FALSE", must match the RAM setting; RAM read latency LAT = 1 ("FALSE") or 2 ("TRUE")

Ports:
clk  in  1  single clock; also drives RAM wclk/rclk
rst_n  in  1  asynchronous active-low reset
s_data  in  DATA_WIDTH  input stream data
s_valid  in  1  input data valid
s_ready  out  1  controller can accept a word
m_data  out  DATA_WIDTH  output stream data
m_valid  out  1  output data valid
m_ready  in  1  downstream accepts a word
ram_wdata  out  DATA_WIDTH  to RAM wdata
ram_waddr  out  ADDR_WIDTH  to RAM waddr
ram_we  out  1  to RAM we
ram_raddr  out  ADDR_WIDTH  to RAM raddr
ram_re  out  1  to RAM re
ram_rdata  in  DATA_WIDTH  from RAM rdata
count  out  ADDR_WIDTH+1  total words held (RAM + in flight + skid)
full  out  1  count == DEPTH
empty  out  1  count == 0

Behaviour:
- Reset (rst_n low, async):
  - wptr, rptr, mem_cnt, inflight, skid all cleared.
  - m_valid=0, m_data=0, count=0, empty=1, full=0, ram_re=0.
  - s_ready=0 while in reset; it is gated by an enable flop that sets on the first clk edge after deassertion.
  - Reset mid-operation discards all contents, including reads in flight; a RAM return after reset is ignored.
- Write side:
  - s_ready = en & ~full.
  - push = s_valid & s_ready.
  - ram_we = push, ram_waddr = wptr, ram_wdata = s_data, all combinational.
  - wptr increments on push, wrapping at DEPTH.
- Read issue:
  - pop = m_valid & m_ready.
  - ram_re = (mem_cnt != 0) & ((inflight_cnt + skid_cnt - pop) < LAT+1).
  - ram_raddr = rptr; rptr increments on ram_re, wrapping at DEPTH.
  - mem_cnt tracks words in the RAM not yet read: +push -ram_re; both in one cycle leaves it unchanged.
  - A read never targets a word written in the same cycle, because mem_cnt only reflects committed writes. There is therefore no read/write collision.
- In-flight tracking:
  - LAT-stage shift register of ram_re.
  - The stage-LAT bit marks the edge at which ram_rdata is valid; ram_rdata is captured into the skid on that edge.
- Skid buffer:
  - Circular buffer, depth LAT+1, with its own head/tail pointers.
  - m_valid = skid_cnt != 0; m_data = head entry (registered storage).
  - Capture and pop may occur in the same cycle; skid_cnt is then unchanged.
  - Skid overflow cannot occur given the issue rule; the bench asserts this.
- Counters:
  - count = mem_cnt + inflight_cnt + skid_cnt, maintained as one registered counter: +push -pop.
  - full and empty are derived from count.
  - Push and pop in the same cycle leave count unchanged.
  - When full, a simultaneous pop does not enable a push in that cycle (s_ready is based on current full).
- Latency:
  - Word pushed at edge E0: ram_re in cycle E0..E1, captured at E1+LAT, m_valid high after edge E0+1+LAT.
  - That is 2 cycles for OUTPUT_REG "FALSE", 3 for "TRUE".
- Throughput: with continuous push and m_ready=1, one word per cycle in steady state, for both LAT values.
- Ordering: strict FIFO; data is never dropped or duplicated across pointer wrap.

Test Plan:
- Reset then idle (ADDR_WIDTH=4) -> s_ready=0 during reset, 1 one cycle after release; empty=1, count=0, m_valid=0, ram_we=ram_re=0.
- Push 0x46 at edge E0, m_ready=1, OUTPUT_REG "FALSE" -> ram_we=1, ram_waddr=0; ram_re=1, ram_raddr=0 next cycle; m_valid=1 with m_data=0x46 after edge E0+2; repeat with "TRUE" -> after E0+3.
- Fill with m_ready=0: push 16 words 0x46,0x48,...,0x64 -> full=1, count=16, s_ready=0; a 17th s_valid is not accepted and ram_we stays 0; skid holds LAT+1 words, ram_re stops.
- Drain after fill with m_ready=1 -> m_data sequence 0x46..0x64 in order, one per cycle with no bubbles after first; empty=1, count=0 at end.
- Streaming 50 words with both valid and ready held high (both OUTPUT_REG values) -> pointers wrap past 15 three times; output equals input order; count stays constant in steady state; m_valid continuous.
- Assert rst_n low mid-stream with 5 words held and 1 read in flight -> m_valid=0, count=0 immediately; after release, the next pushed word 0xA5 is the first word output (no stale data).

Source files
------------

// File: rtl/sdp_ram_fifo_ctrl.sv
// sdp_ram_fifo_ctrl: FIFO controller for an external simple dual-port RAM with a read-prefetch skid buffer
module sdp_ram_fifo_ctrl #(
  parameter int    DATA_WIDTH = 8,
  parameter int    ADDR_WIDTH = 9,
  parameter string OUTPUT_REG = "FALSE"
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  output logic                  ram_re,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty
);
  localparam int LAT = (OUTPUT_REG == "TRUE") ? 2 : 1;
  localparam int SD  = LAT + 1;
  localparam int SW  = $clog2(SD);
  localparam int CW  = ADDR_WIDTH + 1;

  logic                  en;
  logic [ADDR_WIDTH-1:0] wptr, rptr;
  logic [ADDR_WIDTH:0]   mem_cnt;
  logic [LAT:1]          inflight;
  logic [DATA_WIDTH-1:0] skid [SD];
  logic [SW-1:0]         head, tail;
  logic [1:0]            skid_cnt, inflight_cnt;
  logic [2:0]            pending;
  logic                  push, pop, cap;

  // handshakes, RAM port drive, and the prefetch issue decision that keeps skid+in-flight within LAT+1
  always_comb begin
    inflight_cnt = '0;
    for (int i = 1; i <= LAT; i++) inflight_cnt = inflight_cnt + 2'(inflight[i]);
    full      = count[ADDR_WIDTH];
    empty     = count == '0;
    s_ready   = en & ~full;
    push      = s_valid & s_ready;
    m_valid   = skid_cnt != '0;
    m_data    = skid[head];
    pop       = m_valid & m_ready;
    cap       = inflight[LAT];
    pending   = 3'(inflight_cnt) + 3'(skid_cnt) - 3'(pop);
    ram_re    = (mem_cnt != '0) & (pending < 3'(SD));
    ram_we    = push;
    ram_waddr = wptr;
    ram_wdata = s_data;
    ram_raddr = rptr;
  end

  // pointers, occupancy counters, read-latency tracking and the post-reset enable
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      en       <= 1'b0;
      wptr     <= '0;
      rptr     <= '0;
      mem_cnt  <= '0;
      count    <= '0;
      inflight <= '0;
    end else begin
      en          <= 1'b1;
      wptr        <= push ? wptr + 1'b1 : wptr;
      rptr        <= ram_re ? rptr + 1'b1 : rptr;
      mem_cnt     <= mem_cnt + CW'(push) - CW'(ram_re);
      count       <= count + CW'(push) - CW'(pop);
      inflight[1] <= ram_re;
      for (int i = 2; i <= LAT; i++) inflight[i] <= inflight[i-1];
    end

  // skid buffer: RAM returns land at the tail, the head is presented downstream
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < SD; i++) skid[i] <= '0;
      head     <= '0;
      tail     <= '0;
      skid_cnt <= '0;
    end else begin
      if (cap) skid[tail] <= ram_rdata;
      tail     <= cap ? (tail == SW'(SD - 1) ? '0 : tail + 1'b1) : tail;
      head     <= pop ? (head == SW'(SD - 1) ? '0 : head + 1'b1) : head;
      skid_cnt <= skid_cnt + 2'(cap) - 2'(pop);
    end
endmodule

// File: tb/tb_sdp_ram_fifo_ctrl.sv
// tb_sdp_ram_fifo_ctrl: checks both RAM latencies against a word-sequence scoreboard plus directed literals
module tb_sdp_ram_fifo_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       s_valid [2], s_ready [2], m_valid [2], m_ready [2];
  logic       ram_we [2], ram_re [2], full [2], empty [2];
  logic [7:0] s_data [2], m_data [2], ram_wdata [2], ram_rdata [2];
  logic [3:0] ram_waddr [2], ram_raddr [2];
  logic [4:0] count [2];
  int nvec = 0, nerr = 0, cyc = 0;

  sdp_ram_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .OUTPUT_REG("FALSE")) u_lat1 (
    .clk(clk), .rst_n(rst_n), .s_data(s_data[0]), .s_valid(s_valid[0]), .s_ready(s_ready[0]),
    .m_data(m_data[0]), .m_valid(m_valid[0]), .m_ready(m_ready[0]), .ram_wdata(ram_wdata[0]),
    .ram_waddr(ram_waddr[0]), .ram_we(ram_we[0]), .ram_raddr(ram_raddr[0]), .ram_re(ram_re[0]),
    .ram_rdata(ram_rdata[0]), .count(count[0]), .full(full[0]), .empty(empty[0]));

  sdp_ram_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .OUTPUT_REG("TRUE")) u_lat2 (
    .clk(clk), .rst_n(rst_n), .s_data(s_data[1]), .s_valid(s_valid[1]), .s_ready(s_ready[1]),
    .m_data(m_data[1]), .m_valid(m_valid[1]), .m_ready(m_ready[1]), .ram_wdata(ram_wdata[1]),
    .ram_waddr(ram_waddr[1]), .ram_we(ram_we[1]), .ram_raddr(ram_raddr[1]), .ram_re(ram_re[1]),
    .ram_rdata(ram_rdata[1]), .count(count[1]), .full(full[1]), .empty(empty[1]));

  // external RAM models: index 0 without, index 1 with the output register
  logic [7:0] ram [2][16];
  logic [7:0] r1 [2], r2 [2];
  always @(posedge clk)
    for (int d = 0; d < 2; d++) begin
      if (ram_we[d] === 1'b1) ram[d][ram_waddr[d]] <= ram_wdata[d];
      if (ram_re[d] === 1'b1) r1[d] <= ram[d][ram_raddr[d]];
      r2[d] <= r1[d];
    end
  assign ram_rdata[0] = r1[0];
  assign ram_rdata[1] = r2[1];

  task automatic chk(string nm, int d, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s (lat%0d): got %0h expected %0h", nm, d + 1, act, exp);
    end
  endtask

  // model: words are numbered by push order; a word is visible LAT+1 cycles after its read is issued
  int pushed [2], issued [2], popped [2];
  bit en_m [2], pu [2], po [2], rd [2];
  logic [7:0] dat [2][1024];
  int iss [2][1024];

  always @(negedge clk)
    for (int d = 0; d < 2; d++) begin
      int c, l;
      bit p, mv, rdy;
      l = d + 1;
      pu[d] = 1'b0; po[d] = 1'b0; rd[d] = 1'b0;
      if (!rst_n) begin
        pushed[d] = 0; issued[d] = 0; popped[d] = 0; en_m[d] = 1'b0;
        chk("rst_s_ready", d, s_ready[d], 0);
        chk("rst_m_valid", d, m_valid[d], 0);
        chk("rst_m_data", d, m_data[d], 0);
        chk("rst_count", d, count[d], 0);
        chk("rst_empty", d, empty[d], 1);
        chk("rst_full", d, full[d], 0);
        chk("rst_ram_re", d, ram_re[d], 0);
      end else begin
        c = pushed[d] - popped[d];
        rdy = en_m[d] && c != 16;
        chk("s_ready", d, s_ready[d], rdy);
        chk("count", d, count[d], c);
        chk("full", d, full[d], c == 16);
        chk("empty", d, empty[d], c == 0);
        p = rdy && s_valid[d] === 1'b1;
        chk("ram_we", d, ram_we[d], p);
        if (p) begin
          chk("ram_waddr", d, ram_waddr[d], pushed[d] % 16);
          chk("ram_wdata", d, ram_wdata[d], s_data[d]);
          dat[d][pushed[d]] = s_data[d];
        end
        mv = issued[d] > popped[d] && iss[d][popped[d]] + l + 1 <= cyc;
        chk("m_valid", d, m_valid[d], mv);
        if (mv) chk("m_data", d, m_data[d], dat[d][popped[d]]);
        if (ram_re[d] === 1'b1) begin
          chk("ram_raddr", d, ram_raddr[d], issued[d] % 16);
          chk("re_has_data", d, pushed[d] > issued[d], 1);
          iss[d][issued[d]] = cyc;
        end
        po[d] = mv && m_ready[d] === 1'b1;
        chk("skid_bound", d, issued[d] + (ram_re[d] === 1'b1) - popped[d] - po[d] <= l + 1, 1);
        pu[d] = p;
        rd[d] = ram_re[d] === 1'b1;
      end
    end

  always @(posedge clk) begin
    cyc++;
    if (rst_n)
      for (int d = 0; d < 2; d++) begin
        if (pu[d]) pushed[d]++;
        if (rd[d]) issued[d]++;
        if (po[d]) popped[d]++;
        en_m[d] = 1'b1;
      end
  end

  task automatic clear_inputs();
    for (int d = 0; d < 2; d++) begin
      s_valid[d] = 1'b0; m_ready[d] = 1'b0; s_data[d] = 8'h00;
    end
  endtask

  task automatic run(int d);
    int l, p0;
    l = d + 1;
    // reset then idle
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk); chk("d_rst_s_ready", d, s_ready[d], 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk); chk("d_rel_s_ready", d, s_ready[d], 0);
    @(negedge clk);
    chk("d_idle_s_ready", d, s_ready[d], 1);
    chk("d_idle_empty", d, empty[d], 1);
    chk("d_idle_count", d, count[d], 0);
    chk("d_idle_m_valid", d, m_valid[d], 0);
    chk("d_idle_ram_we", d, ram_we[d], 0);
    chk("d_idle_ram_re", d, ram_re[d], 0);
    // single-word latency
    @(posedge clk); #1 s_valid[d] = 1'b1; s_data[d] = 8'h46; m_ready[d] = 1'b1;
    @(negedge clk);
    chk("d_lat_ram_we", d, ram_we[d], 1);
    chk("d_lat_ram_waddr", d, ram_waddr[d], 0);
    @(posedge clk); #1 s_valid[d] = 1'b0;
    for (int k = 0; k <= l + 1; k++) begin
      @(negedge clk);
      if (k == 0) begin
        chk("d_lat_ram_re", d, ram_re[d], 1);
        chk("d_lat_ram_raddr", d, ram_raddr[d], 0);
      end
      chk("d_lat_m_valid", d, m_valid[d], k == l + 1);
      if (k == l + 1) chk("d_lat_m_data", d, m_data[d], 8'h46);
    end
    // fill with downstream stalled
    @(posedge clk); #1 m_ready[d] = 1'b0;
    for (int i = 0; i < 16; i++) begin
      s_valid[d] = 1'b1; s_data[d] = 8'h46 + 8'(2 * i);
      @(negedge clk); chk("d_fill_s_ready", d, s_ready[d], 1);
      @(posedge clk); #1;
    end
    s_data[d] = 8'h99;
    @(negedge clk);
    chk("d_full", d, full[d], 1);
    chk("d_full_count", d, count[d], 16);
    chk("d_full_s_ready", d, s_ready[d], 0);
    chk("d_full_ram_we", d, ram_we[d], 0);
    chk("d_full_ram_re", d, ram_re[d], 0);
    chk("d_full_skid_words", d, issued[d] - popped[d], l + 1);
    // drain: one word per cycle, in order
    @(posedge clk); #1 s_valid[d] = 1'b0; m_ready[d] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("d_drain_m_valid", d, m_valid[d], 1);
      chk("d_drain_m_data", d, m_data[d], 8'h46 + 8'(2 * i));
    end
    @(negedge clk);
    chk("d_drain_empty", d, empty[d], 1);
    chk("d_drain_count", d, count[d], 0);
    chk("d_drain_m_valid_end", d, m_valid[d], 0);
    // 50-word stream with both sides always ready
    p0 = popped[d];
    @(posedge clk); #1;
    for (int i = 0; i < 50; i++) begin
      s_valid[d] = 1'b1; s_data[d] = 8'(i * 7 + 3);
      @(negedge clk);
      if (i >= 10) begin
        chk("d_stream_count", d, count[d], l + 2);
        chk("d_stream_m_valid", d, m_valid[d], 1);
      end
      @(posedge clk); #1;
    end
    s_valid[d] = 1'b0;
    for (int t = 0; t < 20 && empty[d] !== 1'b1; t++) @(negedge clk);
    chk("d_stream_empty", d, empty[d], 1);
    @(posedge clk); #1;
    chk("d_stream_pops", d, popped[d] - p0, 50);
    // reset while holding words with a read in flight
    m_ready[d] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_valid[d] = 1'b1; s_data[d] = 8'h10 + 8'(i);
      @(posedge clk); #1;
    end
    s_valid[d] = 1'b0;
    repeat (4) @(posedge clk);
    #1 m_ready[d] = 1'b1;
    @(negedge clk);
    chk("d_mid_count", d, count[d], 5);
    chk("d_mid_ram_re", d, ram_re[d], 1);
    @(posedge clk); #1 rst_n = 1'b0; m_ready[d] = 1'b0;
    #1;
    chk("d_mid_rst_m_valid", d, m_valid[d], 0);
    chk("d_mid_rst_count", d, count[d], 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1 s_valid[d] = 1'b1; s_data[d] = 8'hA5; m_ready[d] = 1'b1;
    @(posedge clk); #1 s_valid[d] = 1'b0;
    for (int t = 0; t < 10 && m_valid[d] !== 1'b1; t++) @(negedge clk);
    chk("d_post_rst_m_valid", d, m_valid[d], 1);
    chk("d_post_rst_m_data", d, m_data[d], 8'hA5);
    @(posedge clk); #1 clear_inputs();
  endtask

  initial begin
    clear_inputs();
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run(0);
    run(1);
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
